ee357_mcpu_fetch_unit: RTL and testbench
========================================

Name: ee357_mcpu_fetch_unit

Overview:
PC / instruction-register / branch-target / memory-data-register block of the EE357 multicycle MIPS datapath. It sits directly downstream of ee357_mcpu_cu: it consumes pcw, pcwc, iord, mr, irw, tw and pcs, and it performs the state-changing register updates those signals command. It feeds op/func back upstream to the control unit, and supplies instruction fields and the memory address to the rest of the datapath.

Parameters:
DATA_W, 32, datapath/address width; fixed at 32 for the jump-address concatenation.
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  asynchronous, active-high reset.
pcw  in  1  PCWrite: unconditional PC load.
pcwc  in  1  PCWriteCond: PC load if the branch condition holds.
iord  in  1  0 = mem_addr from PC, 1 = mem_addr from alu_result.
mr  in  1  MemRead: MDR captures mem_rdata.
irw  in  1  IRWrite: IR captures mem_rdata.
tw  in  1  TargetWrite: target register captures alu_result.
pcs  in  2  PCSource: 00 alu_result, 01 target, 10 jump address, 11 reserved.
alu_result  in  32  combinational ALU output.
alu_zero  in  1  ALU zero flag.
mem_rdata  in  32  memory read data, combinational to mem_addr.
mem_addr  out  32  memory address.
pc  out  32  current PC register.
ir  out  32  instruction register.
op  out  6  ir[31:26], to control unit.
func  out  6  ir[5:0], to control unit.
rs, rt, rd  out  5 each  ir[25:21], ir[20:16], ir[15:11].
imm  out  16  ir[15:0].
target  out  32  branch target register.
mdr  out  32  memory data register.

Behaviour:
- Reset (asynchronous, immediate on rst=1): pc=RESET_PC, ir=0 (therefore op=0 and func=0), target=0, mdr=0.
- mem_addr is combinational: iord ? alu_result : pc. There is no added latency.
- Branch condition, combinational: taken = (op==6'b000100 & alu_zero) | (op==6'b000101 & ~alu_zero). For any other opcode, taken=0.
- pc_en = (pcw | (pcwc & taken)) & (pcs != 2'b11).
- next_pc by pcs:
  - 00: alu_result.
  - 01: target.
  - 10: {pc[31:28], ir[25:0], 2'b00}, formed from the current (already incremented) pc.
  - 11: pc. The PC holds, even when pcw=1.
- All register updates happen on the same rising edge, each with its own enable:
  - pc <= next_pc when pc_en.
  - ir <= mem_rdata when irw.
  - target <= alu_result when tw.
  - mdr <= mem_rdata when mr.
- Simultaneous pcw & irw (fetch state): IR captures the word at the OLD pc, because mem_addr uses pre-edge pc and iord=0. PC gets alu_result (PC+4) on the same edge.
- Simultaneous tw with pcs=01: the PC loads the OLD target value, and the target updates on the same edge.
- ir is stable between irw pulses, so op/func are stable through decode/execute.
- PC wraps modulo 2^32 (from alu_result). No alignment check and no correction are applied.
- Reset asserted mid-instruction: all registers return to reset values immediately. The first fetch after release uses RESET_PC.

Optional Feature:
EE357_FETCH_PERF_EN:
- Defined: adds 32-bit counters and two output ports, instr_count and br_taken_count, both reset to 0.
  - instr_count increments on each edge with irw=1.
  - br_taken_count increments on each edge with pcwc & taken & pcs!=11.
  - Both counters wrap at 2^32.
- Undefined: neither the counters nor the ports exist, and behaviour is otherwise identical.

Decomposition:
- Package ee357_mcpu_pkg holds:
  - opcode constants OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_JMP, OP_ADDI, OP_JAL;
  - PCS encodings PCS_ALU=00, PCS_TGT=01, PCS_JMP=10, PCS_RSV=11.
- Shared with ee357_mcpu_cu.
- One sub-module, ee357_mcpu_en_reg: a width-parameterised, enabled register with async active-high reset and reset-value parameter. It is instantiated for pc, ir, target and mdr.

Test Plan:
1. Reset: rst=1 mid-run with pc=0x40 -> pc=0, ir=0, op=0, func=0, target=0, mdr=0 immediately without a clock edge. Release, then pcw=1, irw=1, pcs=00, alu_result=4, mem_rdata=0x8C220008 -> pc=4, ir=0x8C220008, op=6'b100011, rt=2, imm=8.
2. Load path: iord=1, alu_result=0x100 -> mem_addr=0x100. mr=1, mem_rdata=0xDEADBEEF -> mdr=0xDEADBEEF after the edge. With iord=0, mem_addr=pc.
3. BEQ: ir op=000100, tw=1, alu_result=0x20 -> target=0x20. Next cycle pcwc=1, pcs=01, alu_zero=1 -> pc=0x20. Repeat with alu_zero=0 -> pc unchanged. BNE opcode inverts both outcomes.
4. Jump: pc=0x3000_0004, ir=0x0800_0010, pcw=1, pcs=10 -> pc=0x3000_0040.
5. Reserved/corner: pcw=1, pcs=11 -> pc holds. pcwc=1 with op=OP_LW and alu_zero=1 -> pc holds. alu_result=0xFFFF_FFFC+4 wraps so pc loads 0.
6. EE357_FETCH_PERF_EN build: 3 fetches and 1 taken BEQ -> instr_count=3, br_taken_count=1. rst clears both to 0.

Source files
------------

// File: rtl/ee357_mcpu_pkg.sv
// ee357_mcpu_pkg
// Shared constants for the EE357 multicycle MIPS datapath and its control unit:
// opcode values for the supported instructions and the PCSource encodings.
package ee357_mcpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JMP   = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {
        PCS_ALU = 2'b00,
        PCS_TGT = 2'b01,
        PCS_JMP = 2'b10,
        PCS_RSV = 2'b11
    } pcs_e;

endpackage

// File: rtl/ee357_mcpu_en_reg.sv
// ee357_mcpu_en_reg
// Width-parameterised register with load enable and asynchronous active-high
// reset to RST_VAL.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   en    - load enable
//   d     - data in
//   q     - registered data out
module ee357_mcpu_en_reg #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= RST_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/ee357_mcpu_fetch_unit.sv
// ee357_mcpu_fetch_unit
// PC, instruction register, branch-target register and memory data register of
// the EE357 multicycle MIPS datapath. Executes the register updates commanded
// by ee357_mcpu_cu and returns op/func to it.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   pcw, pcwc           - unconditional / branch-conditional PC write
//   iord                - memory address select (0 = pc, 1 = alu_result)
//   mr, irw, tw         - MDR, IR and target register write enables
//   pcs                 - PC source select (ALU, target, jump, reserved)
//   alu_result,alu_zero - ALU output and zero flag
//   mem_rdata           - memory read data
//   mem_addr            - memory address (combinational)
//   pc, ir, target, mdr - architectural registers
//   op..imm             - instruction fields decoded from ir
// Build option EE357_FETCH_PERF_EN adds instr_count and br_taken_count.
module ee357_mcpu_fetch_unit
    import ee357_mcpu_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pcw,
    input  logic              pcwc,
    input  logic              iord,
    input  logic              mr,
    input  logic              irw,
    input  logic              tw,
    input  logic [1:0]        pcs,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [5:0]        op,
    output logic [5:0]        func,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [15:0]       imm,
    output logic [DATA_W-1:0] target,
    output logic [DATA_W-1:0] mdr
`ifdef EE357_FETCH_PERF_EN
    ,
    output logic [31:0]       instr_count,
    output logic [31:0]       br_taken_count
`endif
);

    logic              w_taken;
    logic              w_pc_en;
    logic [DATA_W-1:0] w_next_pc;

    assign op   = ir[31:26];
    assign rs   = ir[25:21];
    assign rt   = ir[20:16];
    assign rd   = ir[15:11];
    assign imm  = ir[15:0];
    assign func = ir[5:0];

    assign mem_addr = iord ? alu_result : pc;

    assign w_taken = ((op == OP_BEQ) &&  alu_zero) ||
                     ((op == OP_BNE) && !alu_zero);

    // The reserved source suppresses the write entirely, even under pcw.
    assign w_pc_en = (pcw || (pcwc && w_taken)) && (pcs != PCS_RSV);

    always_comb begin
        w_next_pc = pc;
        case (pcs)
            PCS_ALU: w_next_pc = alu_result;
            PCS_TGT: w_next_pc = target;
            // Jump uses the already-incremented pc for its upper nibble.
            PCS_JMP: w_next_pc = {pc[31:28], ir[25:0], 2'b00};
            default: w_next_pc = pc;
        endcase
    end

    ee357_mcpu_en_reg #(.W(DATA_W), .RST_VAL(RESET_PC)) u_pc_reg (
        .clk(clk), .rst(rst), .en(w_pc_en), .d(w_next_pc), .q(pc)
    );

    ee357_mcpu_en_reg #(.W(DATA_W), .RST_VAL('0)) u_ir_reg (
        .clk(clk), .rst(rst), .en(irw), .d(mem_rdata), .q(ir)
    );

    ee357_mcpu_en_reg #(.W(DATA_W), .RST_VAL('0)) u_target_reg (
        .clk(clk), .rst(rst), .en(tw), .d(alu_result), .q(target)
    );

    ee357_mcpu_en_reg #(.W(DATA_W), .RST_VAL('0)) u_mdr_reg (
        .clk(clk), .rst(rst), .en(mr), .d(mem_rdata), .q(mdr)
    );

`ifdef EE357_FETCH_PERF_EN
    logic [31:0] r_instr_count;
    logic [31:0] r_br_taken_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_count    <= '0;
            r_br_taken_count <= '0;
        end else begin
            if (irw)
                r_instr_count <= r_instr_count + 32'd1;
            if (pcwc && w_taken && (pcs != PCS_RSV))
                r_br_taken_count <= r_br_taken_count + 32'd1;
        end
    end

    assign instr_count    = r_instr_count;
    assign br_taken_count = r_br_taken_count;
`endif

endmodule

// File: tb/tb_ee357_mcpu_fetch_unit.sv
// tb_ee357_mcpu_fetch_unit
// Directed scenarios plus randomized cycles against a behavioural model of the
// fetch unit's registers. Define EE357_FETCH_PERF_EN to also cover the counters.
module tb_ee357_mcpu_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcw, pcwc, iord, mr, irw, tw, alu_zero;
    logic [1:0]  pcs;
    logic [31:0] alu_result, mem_rdata;
    logic [31:0] mem_addr, pc, ir, target, mdr;
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
`ifdef EE357_FETCH_PERF_EN
    logic [31:0] instr_count, br_taken_count;
`endif

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [31:0] m_pc, m_ir, m_target, m_mdr;
    logic [31:0] m_icnt, m_bcnt;

    always #5 clk = ~clk;

    ee357_mcpu_fetch_unit #(.DATA_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .pcw(pcw), .pcwc(pcwc), .iord(iord), .mr(mr),
        .irw(irw), .tw(tw), .pcs(pcs), .alu_result(alu_result),
        .alu_zero(alu_zero), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
        .pc(pc), .ir(ir), .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd),
        .imm(imm), .target(target), .mdr(mdr)
`ifdef EE357_FETCH_PERF_EN
        , .instr_count(instr_count), .br_taken_count(br_taken_count)
`endif
    );

    task automatic idle();
        pcw = 0; pcwc = 0; iord = 0; mr = 0; irw = 0; tw = 0; pcs = 2'b00;
        alu_zero = 0; alu_result = 32'h0; mem_rdata = 32'h0;
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ir = 32'h0; m_target = 32'h0; m_mdr = 32'h0;
        m_icnt = 0; m_bcnt = 0;
    endtask

    // One clock edge: model decides the next state from the current inputs,
    // then outputs are sampled 1 time unit after the edge.
    task automatic step();
        bit          br;
        bit          load;
        logic [31:0] npc;
        br = 0;
        if (m_ir[31:26] == 6'd4 && alu_zero)  br = 1;
        if (m_ir[31:26] == 6'd5 && !alu_zero) br = 1;
        load = (pcw || (pcwc && br)) && pcs != 2'b11;
        npc = m_pc;
        if (load) begin
            if (pcs == 2'b00)      npc = alu_result;
            else if (pcs == 2'b01) npc = m_target;
            else                   npc = (m_pc & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 4);
        end
        if (irw) m_icnt = m_icnt + 1;
        if (pcwc && br && pcs != 2'b11) m_bcnt = m_bcnt + 1;
        @(posedge clk);
        #1;
        m_pc = npc;
        if (irw) m_ir = mem_rdata;
        if (tw)  m_target = alu_result;
        if (mr)  m_mdr = mem_rdata;
    endtask

    task automatic test_reset();
        idle();
        pcw = 1; alu_result = 32'h40; irw = 1; mem_rdata = 32'h1234_5678;
        tw = 1; mr = 1;
        step();
        idle();
        total++; if (pc !== 32'h40) begin bad++; $display("FAIL reset_pre pc got=%h exp=%h", pc, 32'h40); end
        @(posedge clk); #3;
        rst = 1;
        #1;
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_async pc got=%h exp=0", pc); end
        total++; if (ir !== 32'h0) begin bad++; $display("FAIL reset_async ir got=%h exp=0", ir); end
        total++; if (op !== 6'h0 || func !== 6'h0) begin bad++; $display("FAIL reset_async op/func got=%h/%h exp=0/0", op, func); end
        total++; if (target !== 32'h0) begin bad++; $display("FAIL reset_async target got=%h exp=0", target); end
        total++; if (mdr !== 32'h0) begin bad++; $display("FAIL reset_async mdr got=%h exp=0", mdr); end
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_first_fetch mem_addr got=%h exp=0", mem_addr); end
        pcw = 1; irw = 1; pcs = 2'b00; alu_result = 32'h4; mem_rdata = 32'h8C22_0008;
        step();
        idle();
        total++; if (pc !== 32'h4) begin bad++; $display("FAIL fetch pc got=%h exp=4", pc); end
        total++; if (ir !== 32'h8C22_0008) begin bad++; $display("FAIL fetch ir got=%h exp=8c220008", ir); end
        total++; if (op !== 6'b100011) begin bad++; $display("FAIL fetch op got=%b exp=100011", op); end
        total++; if (rt !== 5'd2 || imm !== 16'd8) begin bad++; $display("FAIL fetch rt/imm got=%0d/%0d exp=2/8", rt, imm); end
    endtask

    task automatic test_load_path();
        idle();
        iord = 1; alu_result = 32'h100; #1;
        total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL load mem_addr got=%h exp=100", mem_addr); end
        mr = 1; mem_rdata = 32'hDEAD_BEEF;
        step();
        idle();
        total++; if (mdr !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load mdr got=%h exp=deadbeef", mdr); end
        #1;
        total++; if (mem_addr !== m_pc) begin bad++; $display("FAIL load mem_addr_pc got=%h exp=%h", mem_addr, m_pc); end
    endtask

    task automatic test_branch();
        logic [31:0] held;
        // BEQ
        idle(); irw = 1; mem_rdata = 32'h1000_0003; step();
        idle(); tw = 1; alu_result = 32'h20; step();
        total++; if (target !== 32'h20) begin bad++; $display("FAIL beq target got=%h exp=20", target); end
        idle(); pcwc = 1; pcs = 2'b01; alu_zero = 1; step();
        total++; if (pc !== 32'h20) begin bad++; $display("FAIL beq_taken pc got=%h exp=20", pc); end
        held = pc;
        idle(); pcwc = 1; pcs = 2'b01; alu_zero = 0; step();
        total++; if (pc !== held) begin bad++; $display("FAIL beq_not_taken pc got=%h exp=%h", pc, held); end
        // BNE with simultaneous target write: PC takes the old target
        idle(); irw = 1; mem_rdata = 32'h1400_0001; step();
        held = pc;
        idle(); pcwc = 1; pcs = 2'b01; alu_zero = 1; step();
        total++; if (pc !== held) begin bad++; $display("FAIL bne_not_taken pc got=%h exp=%h", pc, held); end
        idle(); pcwc = 1; pcs = 2'b01; alu_zero = 0; tw = 1; alu_result = 32'h80; step();
        total++; if (pc !== 32'h20) begin bad++; $display("FAIL bne_taken_old_target pc got=%h exp=20", pc); end
        total++; if (target !== 32'h80) begin bad++; $display("FAIL bne_new_target got=%h exp=80", target); end
        idle();
    endtask

    task automatic test_jump();
        idle(); pcw = 1; alu_result = 32'h3000_0004; irw = 1; mem_rdata = 32'h0800_0010; step();
        idle(); pcw = 1; pcs = 2'b10; alu_result = 32'h5555_5555; step();
        total++; if (pc !== 32'h3000_0040) begin bad++; $display("FAIL jump pc got=%h exp=30000040", pc); end
        idle();
    endtask

    task automatic test_corner();
        logic [31:0] held;
        logic [31:0] wrap;
        held = pc;
        idle(); pcw = 1; pcs = 2'b11; alu_result = 32'h1234_5678; step();
        total++; if (pc !== held) begin bad++; $display("FAIL reserved_pcs pc got=%h exp=%h", pc, held); end
        idle(); irw = 1; mem_rdata = 32'h8C00_0000; step();
        idle(); pcwc = 1; pcs = 2'b00; alu_zero = 1; alu_result = 32'h9999_0000; step();
        total++; if (pc !== held) begin bad++; $display("FAIL lw_pcwc pc got=%h exp=%h", pc, held); end
        idle(); pcw = 1; alu_result = 32'hFFFF_FFFC; step();
        wrap = 32'hFFFF_FFFC;
        wrap = wrap + 32'd4;
        idle(); pcw = 1; alu_result = wrap; step();
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL pc_wrap pc got=%h exp=0", pc); end
        idle();
    endtask

    task automatic test_random();
        logic [5:0] ops [4];
        logic [31:0] exp_addr;
        ops[0] = 6'd4; ops[1] = 6'd5; ops[2] = 6'b100011; ops[3] = 6'd2;
        for (int i = 0; i < 300; i++) begin
            pcw = 1'($urandom); pcwc = 1'($urandom); iord = 1'($urandom);
            mr = 1'($urandom); irw = 1'($urandom); tw = 1'($urandom);
            pcs = 2'($urandom); alu_zero = 1'($urandom);
            alu_result = $urandom;
            mem_rdata = {ops[$urandom_range(0, 3)], 26'($urandom)};
            #1;
            exp_addr = iord ? alu_result : m_pc;
            total++; if (mem_addr !== exp_addr) begin bad++; $display("FAIL rnd mem_addr i=%0d got=%h exp=%h", i, mem_addr, exp_addr); end
            step();
            total++; if (pc !== m_pc) begin bad++; $display("FAIL rnd pc i=%0d got=%h exp=%h", i, pc, m_pc); end
            total++; if (ir !== m_ir) begin bad++; $display("FAIL rnd ir i=%0d got=%h exp=%h", i, ir, m_ir); end
            total++; if (target !== m_target) begin bad++; $display("FAIL rnd target i=%0d got=%h exp=%h", i, target, m_target); end
            total++; if (mdr !== m_mdr) begin bad++; $display("FAIL rnd mdr i=%0d got=%h exp=%h", i, mdr, m_mdr); end
            total++;
            if ({op, rs, rt, rd, func} !== {m_ir[31:26], m_ir[25:21], m_ir[20:16], m_ir[15:11], m_ir[5:0]} || imm !== m_ir[15:0]) begin
                bad++; $display("FAIL rnd fields i=%0d got=%h exp=%h", i, {op, rs, rt, rd, func}, {m_ir[31:26], m_ir[25:21], m_ir[20:16], m_ir[15:11], m_ir[5:0]});
            end
`ifdef EE357_FETCH_PERF_EN
            total++; if (instr_count !== m_icnt || br_taken_count !== m_bcnt) begin bad++; $display("FAIL rnd counters i=%0d got=%0d/%0d exp=%0d/%0d", i, instr_count, br_taken_count, m_icnt, m_bcnt); end
`endif
        end
        idle();
    endtask

`ifdef EE357_FETCH_PERF_EN
    task automatic test_perf();
        idle(); @(posedge clk); #3; rst = 1; #1;
        @(posedge clk); #1; rst = 0; model_reset();
        for (int i = 0; i < 3; i++) begin
            idle(); pcw = 1; irw = 1; alu_result = 32'h4 * (i + 1); mem_rdata = 32'h1000_0002; step();
        end
        idle(); tw = 1; alu_result = 32'h100; step();
        idle(); pcwc = 1; pcs = 2'b01; alu_zero = 1; step();
        idle();
        total++; if (instr_count !== 32'd3) begin bad++; $display("FAIL perf instr_count got=%0d exp=3", instr_count); end
        total++; if (br_taken_count !== 32'd1) begin bad++; $display("FAIL perf br_taken_count got=%0d exp=1", br_taken_count); end
        #2; rst = 1; #1;
        total++; if (instr_count !== 32'd0 || br_taken_count !== 32'd0) begin bad++; $display("FAIL perf reset got=%0d/%0d exp=0/0", instr_count, br_taken_count); end
        @(posedge clk); #1; rst = 0; model_reset();
    endtask
`endif

    initial begin
        idle();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        test_reset();
        test_load_path();
        test_branch();
        test_jump();
        test_corner();
        test_random();
`ifdef EE357_FETCH_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
